// File: rtl/cordic_seq.sv
// Sequencer that turns a phase accumulator into first-octant angles and octant
// indices for a downstream CORDIC pipeline. It issues bursts of samples, drains
// the pipeline and then pulses done.
module cordic_seq #(
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned PIPE_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [ACC_W-1:0] freq_word,
  input  logic [ACC_W-1:0] phase_off,
  input  logic [15:0]      num_samples,
  output logic [15:0]      angle,
  output logic [2:0]       index_qua,
  output logic             wen,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sample_cnt
);

  localparam int unsigned CntW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [CntW-1:0] DrainLast = CntW'(PIPE_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] freq_q, freq_d;
  logic [15:0]      num_q, num_d;
  logic [15:0]      angle_q, angle_d;
  logic [2:0]       index_q, index_d;
  logic             wen_q, wen_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [CntW-1:0]  drain_cnt_q, drain_cnt_d;
  logic [15:0]      raw_angle;

  assign raw_angle = acc_q[ACC_W-4 -: 16];

  // Next-state logic: sample issue, burst termination and drain timing.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    freq_d      = freq_q;
    num_d       = num_q;
    angle_d     = angle_q;
    index_d     = index_q;
    wen_d       = 1'b0;
    cnt_d       = cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          acc_d       = phase_off;
          freq_d      = freq_word;
          num_d       = num_samples;
          cnt_d       = 16'd0;
          drain_cnt_d = '0;
          state_d     = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          // Stop beats the final sample when both land on the same edge.
          drain_cnt_d = '0;
          state_d     = StDrain;
        end else begin
          wen_d   = 1'b1;
          index_d = acc_q[ACC_W-1 -: 3];
          // Odd octants are mirrored so the CORDIC only sees the first octant.
          angle_d = acc_q[ACC_W-3] ? (16'hFFFF - raw_angle) : raw_angle;
          acc_d   = acc_q + freq_q;
          cnt_d   = cnt_q + 16'd1;
          if ((num_q != 16'd0) && (cnt_q == num_q - 16'd1)) begin
            drain_cnt_d = '0;
            state_d     = StDrain;
          end
        end
      end
      StDrain: begin
        // Only cycles with wen low count, so the final sample's strobe cycle
        // does not eat into the pipeline drain time.
        if (!wen_q) begin
          if (drain_cnt_q == DrainLast) begin
            state_d = StDone;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      freq_q      <= '0;
      num_q       <= 16'd0;
      angle_q     <= 16'd0;
      index_q     <= 3'd0;
      wen_q       <= 1'b0;
      cnt_q       <= 16'd0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      freq_q      <= freq_d;
      num_q       <= num_d;
      angle_q     <= angle_d;
      index_q     <= index_d;
      wen_q       <= wen_d;
      cnt_q       <= cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Outputs: registered sample path, status decoded from state.
  always_comb begin
    angle      = angle_q;
    index_qua  = index_q;
    wen        = wen_q;
    sample_cnt = cnt_q;
    busy       = (state_q == StRun) || (state_q == StDrain);
    done       = (state_q == StDone);
  end

endmodule

// File: tb/tb_cordic_seq.sv
// Directed bench for cordic_seq: bursts, stop, drain/done timing, reset abort.
module tb_cordic_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] freq_word = '0;
  logic [31:0] phase_off = '0;
  logic [15:0] num_samples = '0;
  logic [15:0] angle;
  logic [2:0]  index_qua;
  logic        wen;
  logic        busy;
  logic        done;
  logic [15:0] sample_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cordic_seq #(
    .ACC_W      (32),
    .PIPE_DEPTH (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .freq_word   (freq_word),
    .phase_off   (phase_off),
    .num_samples (num_samples),
    .angle       (angle),
    .index_qua   (index_qua),
    .wen         (wen),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] ph, input logic [31:0] fw, input logic [15:0] n);
    phase_off   = ph;
    freq_word   = fw;
    num_samples = n;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Scenario 1/2 burst; with inject, start is pulsed in RUN and start+stop in DRAIN.
  task automatic burst8(input bit inject, input string nm);
    pulse_start(32'h0, 32'h2000_0000, 16'd8);
    chk({nm, " first cycle wen"}, 32'(wen), 0);
    chk({nm, " first cycle busy"}, 32'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      if (inject && i == 2) begin
        start = 1'b1;
        phase_off = 32'h1234_5678;
        num_samples = 16'd3;
      end
      tick();
      start = 1'b0;
      chk({nm, " wen"}, 32'(wen), 1);
      chk({nm, " index"}, 32'(index_qua), i);
      chk({nm, " angle"}, 32'(angle), (i % 2 == 1) ? 32'hFFFF : 32'h0);
      chk({nm, " cnt"}, 32'(sample_cnt), i + 1);
    end
    for (int k = 0; k < 16; k++) begin
      if (inject && k == 5) begin
        start = 1'b1;
        stop  = 1'b1;
      end
      tick();
      start = 1'b0;
      stop  = 1'b0;
      chk({nm, " drain busy"}, 32'(busy), 1);
      chk({nm, " drain wen"}, 32'(wen), 0);
      chk({nm, " drain done"}, 32'(done), 0);
    end
    tick();
    chk({nm, " done pulse"}, 32'(done), 1);
    chk({nm, " done busy"}, 32'(busy), 0);
    tick();
    chk({nm, " done clears"}, 32'(done), 0);
    chk({nm, " hold angle"}, 32'(angle), 32'hFFFF);
    chk({nm, " hold index"}, 32'(index_qua), 7);
    chk({nm, " hold cnt"}, 32'(sample_cnt), 8);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst wen", 32'(wen), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst angle", 32'(angle), 0);
    chk("rst index", 32'(index_qua), 0);
    chk("rst cnt", 32'(sample_cnt), 0);
    @(negedge clk);
    reset = 1'b1;

    // stop in IDLE is ignored
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("idle stop busy", 32'(busy), 0);
    chk("idle stop wen", 32'(wen), 0);

    // Scenarios 1, 2 and 4
    burst8(1'b0, "s1");
    burst8(1'b1, "s4");

    // Scenario 3: continuous mode, stopped after 5 samples
    pulse_start(32'h0, 32'h0000_2000, 16'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3 wen", 32'(wen), 1);
      chk("s3 angle", 32'(angle), i);
      chk("s3 index", 32'(index_qua), 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("s3 stop wen", 32'(wen), 0);
    chk("s3 stop busy", 32'(busy), 1);
    chk("s3 cnt", 32'(sample_cnt), 5);
    chk("s3 hold angle", 32'(angle), 4);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("s3 drain busy", 32'(busy), 1);
      chk("s3 drain done", 32'(done), 0);
    end
    tick();
    chk("s3 done", 32'(done), 1);
    tick();

    // Stop coinciding with the final sample wins; simultaneous start+stop in IDLE starts.
    stop = 1'b1;
    pulse_start(32'h0, 32'h0000_2000, 16'd3);
    stop = 1'b0;
    chk("ss busy", 32'(busy), 1);
    tick();
    tick();
    chk("ss cnt2", 32'(sample_cnt), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ss final wen", 32'(wen), 0);
    chk("ss final cnt", 32'(sample_cnt), 2);
    for (int k = 0; k < 16; k++) tick();
    chk("ss done", 32'(done), 1);
    tick();

    // Scenario 5: reset at the third wen cycle
    pulse_start(32'h0, 32'h2000_0000, 16'd8);
    tick();
    tick();
    tick();
    chk("s5 wen3", 32'(wen), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("s5 async wen", 32'(wen), 0);
    chk("s5 async busy", 32'(busy), 0);
    chk("s5 async angle", 32'(angle), 0);
    chk("s5 async index", 32'(index_qua), 0);
    chk("s5 async cnt", 32'(sample_cnt), 0);
    tick();
    chk("s5 no done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    burst8(1'b0, "s5 rerun");

    // Scenario 6: wrap and reflection
    pulse_start(32'hFFFF_E000, 32'h0000_2000, 16'd2);
    tick();
    chk("s6 index0", 32'(index_qua), 7);
    chk("s6 angle0", 32'(angle), 0);
    tick();
    chk("s6 index1", 32'(index_qua), 0);
    chk("s6 angle1", 32'(angle), 0);
    chk("s6 cnt", 32'(sample_cnt), 2);
    tick();
    chk("s6 after wen", 32'(wen), 0);
    chk("s6 drain busy", 32'(busy), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_seq.md
CORDIC_SEQ -- requirements
Module: cordic_seq

Interface
REQ-001 The block SHALL expose the following parameters:
- ACC_W, 32: phase accumulator width, minimum 19.
- PIPE_DEPTH, 16: CORDIC pipeline latency in clocks that the drain phase waits out, minimum 1.
REQ-002 The block SHALL expose the following ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a burst; sampled in IDLE only.
- stop  in  1  early terminate; sampled in RUN only.
- freq_word  in  ACC_W  phase increment per sample; latched at start.
- phase_off  in  ACC_W  initial phase; latched at start.
- num_samples  in  16  burst length; 0 means continuous until stop; latched at start.
- angle  out  16  reduced first-octant angle to the CORDIC input.
- index_qua  out  3  octant index to the CORDIC mirror stage.
- wen  out  1  sample-valid strobe to the CORDIC pipeline.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at burst completion.
- sample_cnt  out  16  samples issued in the current burst.

Function
REQ-003 The state machine SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-004 In IDLE with start=1 at an edge, the block SHALL, at that edge, load acc<=phase_off, latch freq_word and num_samples, set sample_cnt<=0, and go to RUN.
REQ-005 At each RUN edge without stop, the block SHALL register wen<=1, index_qua<=acc[ACC_W-1:ACC_W-3] and angle<=acc[ACC_W-4:ACC_W-19], then update acc<=acc+freq_word (modulo 2^ACC_W) and sample_cnt<=sample_cnt+1.
REQ-006 When index_qua[0]=1 (odd octant), angle SHALL be registered as 16'hFFFF minus acc[ACC_W-4:ACC_W-19] (octant reflection); otherwise it SHALL be registered unmodified.
REQ-007 With latched num_samples=N>0, the RUN edge issuing sample N SHALL also move the state to DRAIN, so wen is high for exactly N consecutive cycles starting one clock after the start edge.
REQ-008 With N=0, RUN SHALL continue until stop; sample_cnt SHALL wrap modulo 2^16 and acc SHALL wrap freely.
REQ-009 stop=1 at a RUN edge SHALL issue no sample (wen<=0) and SHALL move the state to DRAIN; if stop coincides with the edge that would issue sample N, stop wins and sample N is not issued.
REQ-010 DRAIN SHALL hold wen=0 for exactly PIPE_DEPTH cycles, then move to DONE.
REQ-011 DONE SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in every other state.
REQ-012 busy SHALL be 1 exactly in RUN and DRAIN.
REQ-013 start SHALL be ignored outside IDLE, and stop SHALL be ignored outside RUN.
REQ-014 After wen falls, angle, index_qua and sample_cnt SHALL hold their last values until the next start.
REQ-015 In IDLE, wen SHALL be 0, and a simultaneous start and stop SHALL be treated as start only.

Reset
REQ-016 reset=0 SHALL asynchronously force state=IDLE, acc=0, all latched inputs=0, angle=0, index_qua=0, wen=0, busy=0, done=0, sample_cnt=0, and the drain counter to 0.
REQ-017 Reset asserted mid-RUN or mid-DRAIN SHALL abort the burst with no done pulse.
REQ-018 After release, the block SHALL accept start on the first rising edge.

Verification
REQ-019 Scenario 1: start with phase_off=0, freq_word=32'h2000_0000, N=8 -> wen high 8 cycles; index_qua 0,1,...,7; angle 0000,FFFF,0000,FFFF,...
REQ-020 Scenario 2: same burst with PIPE_DEPTH=16 -> after the last wen, 16 cycles of busy=1 with wen=0, then a single done pulse, then busy=0.
REQ-021 Scenario 3: N=0, freq_word=32'h0000_2000, stop after 5 samples -> sample_cnt=5, angle sequence 0,1,2,3,4, then drain and done.
REQ-022 Scenario 4: start pulsed again during RUN and during DRAIN -> ignored; sample count and done timing unchanged from Scenario 1.
REQ-023 Scenario 5: reset asserted at the third wen cycle -> all outputs 0 immediately, no done pulse; a new start after release runs a full burst.
REQ-024 Scenario 6: phase_off=32'hFFFF_E000, freq_word=32'h0000_2000, N=2 -> index_qua 7 then 0, angle 0000 then 0000 (wrap and reflection checked).
